// File: rtl/ifb_pkg.sv
// Shared types and helpers for the instruction fetch buffer.
// Latency: none (types only). Backpressure: n/a.
package ifb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        FILL   = 3'd4
    } ifb_state_e;

    localparam int WORD_W = 32;

    // Tag covers the word address bits above the index.
    function automatic int tag_w(input int idx_w);
        return WORD_W - 2 - idx_w;
    endfunction

endpackage

// File: rtl/ifb_tag_store.sv
// Direct-mapped valid/tag/data arrays: combinational read, one write port, bulk flush.
// Latency: read 0 cycles, write visible next cycle. Backpressure: none; flush beats a same-cycle valid write.
module ifb_tag_store
    import ifb_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = tag_w(IDX_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [WORD_W-1:0]  data_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: nothing reads it while its valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Direct-mapped instruction buffer between CPU fetch and memory controller; IFB_PERF_COUNTERS_EN adds hit/miss counters.
// Latency: hit 0 cycles; miss 3 + controller wait cycles + 1. Backpressure: cpu_stall held high until the entry is filled.
module inst_fetch_buffer
    import ifb_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] cpu_pc,
    output logic [WORD_W-1:0] cpu_inst,
    output logic              cpu_stall,
    input  logic              flush,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_inst,
    input  logic              mem_stall
`ifdef IFB_PERF_COUNTERS_EN
    ,
    output logic [15:0]       perf_hits,
    output logic [15:0]       perf_misses
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = tag_w(IDX_W);

    ifb_state_e        state_q;
    logic              last_valid;
    logic [WORD_W-1:0] last_addr;
    logic [WORD_W-1:0] last_data;

    logic [WORD_W-1:0] pc_word;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0] rd_data;
    logic              hit;

    assign pc_word = cpu_pc & 32'hFFFF_FFFC;

    ifb_tag_store #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_tag_store (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .rd_idx   (cpu_pc[2 +: IDX_W]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (state_q == FILL),
        .wr_idx   (mem_addr[2 +: IDX_W]),
        .wr_tag   (mem_addr[WORD_W-1 -: TAG_W]),
        .wr_data  (last_data)
    );

    assign hit       = rd_valid && (rd_tag == cpu_pc[WORD_W-1 -: TAG_W]) && (state_q == IDLE);
    assign cpu_inst  = hit ? rd_data : last_data;
    assign cpu_stall = !hit;

    // The controller only reacts to address changes, so a repeat of the
    // last word is served from last_data and the reset-latched address 0
    // is waited on directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_addr   <= '0;
            last_valid <= 1'b0;
            last_addr  <= '0;
            last_data  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        if (last_valid && (pc_word == last_addr)) begin
                            state_q <= FILL;
                        end else if (!last_valid && (pc_word == mem_addr)) begin
                            state_q <= WAIT;
                        end else begin
                            mem_addr <= pc_word;
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE:  state_q <= SETTLE;
                SETTLE: state_q <= WAIT;
                WAIT: begin
                    if (!mem_stall) begin
                        last_data  <= mem_inst;
                        last_addr  <= mem_addr;
                        last_valid <= 1'b1;
                        state_q    <= FILL;
                    end
                end
                FILL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IFB_PERF_COUNTERS_EN
    // Every IDLE miss leaves IDLE, so !hit in IDLE marks a miss transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (state_q == IDLE) begin
            if (hit && (perf_hits != 16'hFFFF)) begin
                perf_hits <= perf_hits + 16'd1;
            end
            if (!hit && (perf_misses != 16'hFFFF)) begin
                perf_misses <= perf_misses + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer with a simple address-change-driven controller model.
// Latency: n/a. Backpressure: controller pulses mem_stall low two cycles after each new address.
module tb_inst_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_inst;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        mem_stall;

    logic        ctl_auto;
    logic        ctl_stall;
    logic [31:0] ctl_inst;
    logic        man_stall;
    logic [31:0] man_inst;
    logic [31:0] ctl_addr;
    int          ctl_cnt;
    bit          ctl_pending;
    int          req_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign mem_stall = ctl_auto ? ctl_stall : man_stall;
    assign mem_inst  = ctl_auto ? ctl_inst  : man_inst;

    inst_fetch_buffer #(.ENTRIES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_pc    (cpu_pc),
        .cpu_inst  (cpu_inst),
        .cpu_stall (cpu_stall),
        .flush     (flush),
        .mem_addr  (mem_addr),
        .mem_inst  (mem_inst),
        .mem_stall (mem_stall)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00500093;
        return {16'hA5A5, a[15:0]};
    endfunction

    // Controller: sees a new address, then pulses stall low once, landing in WAIT.
    initial begin
        ctl_stall   = 1'b1;
        ctl_inst    = '0;
        ctl_addr    = '0;
        ctl_cnt     = 0;
        ctl_pending = 1'b0;
        req_count   = 0;
        forever begin
            @(negedge clk);
            if (ctl_auto) begin
                if (mem_addr !== ctl_addr) begin
                    ctl_addr    = mem_addr;
                    ctl_cnt     = 1;
                    ctl_pending = 1'b1;
                    req_count++;
                    ctl_stall   = 1'b1;
                end else if (ctl_pending) begin
                    if (ctl_cnt == 0) begin
                        ctl_stall   = 1'b0;
                        ctl_inst    = mem_word(ctl_addr);
                        ctl_pending = 1'b0;
                    end else begin
                        ctl_cnt--;
                        ctl_stall = 1'b1;
                    end
                end else begin
                    ctl_stall = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input int budget, output int cyc);
        cyc = 0;
        #1;
        while (cpu_stall && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        flush     = 1'b0;
        cpu_pc    = 32'h0;
        ctl_auto  = 1'b0;
        man_stall = 1'b1;
        man_inst  = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (cpu_stall !== 1'b1) begin fails++; $display("FAIL reset_stall: got %b want 1", cpu_stall); end
        tests++;
        if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        tests++;
        if (cpu_inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h want 0", cpu_inst); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if (cpu_stall !== 1'b1 || mem_addr !== 32'h0) begin
                fails++;
                $display("FAIL first_wait_c%0d: stall=%b addr=%h want stall=1 addr=0", c, cpu_stall, mem_addr);
            end
        end
        @(negedge clk);
        man_stall = 1'b0;
        man_inst  = 32'h00500093;
        @(posedge clk);
        #1;
        tests++;
        if (cpu_stall !== 1'b1) begin fails++; $display("FAIL first_fill_stall: got %b want 1", cpu_stall); end
        @(negedge clk);
        man_stall = 1'b1;
        man_inst  = '0;
        @(posedge clk);
        #1;
        tests++;
        if (cpu_stall !== 1'b0 || cpu_inst !== 32'h00500093) begin
            fails++;
            $display("FAIL first_hit: stall=%b inst=%h want stall=0 inst=00500093", cpu_stall, cpu_inst);
        end
    endtask

    task automatic test_miss_then_hit;
        int cyc;
        ctl_addr = mem_addr;
        ctl_auto = 1'b1;
        @(negedge clk);
        cpu_pc = 32'h4;
        #1;
        tests++;
        if (cpu_stall !== 1'b1 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL pc4_miss: stall=%b addr=%h want stall=1 addr=0", cpu_stall, mem_addr);
        end
        @(posedge clk);
        #1;
        tests++;
        if (mem_addr !== 32'h4) begin fails++; $display("FAIL pc4_addr: got %h want 4", mem_addr); end
        wait_ready(20, cyc);
        tests++;
        if (cpu_stall !== 1'b0 || cpu_inst !== mem_word(32'h4)) begin
            fails++;
            $display("FAIL pc4_fill: stall=%b inst=%h want stall=0 inst=%h", cpu_stall, cpu_inst, mem_word(32'h4));
        end
        @(negedge clk);
        cpu_pc = 32'h0;
        #1;
        tests++;
        if (cpu_stall !== 1'b0 || cpu_inst !== 32'h00500093) begin
            fails++;
            $display("FAIL pc0_rehit: stall=%b inst=%h want stall=0 inst=00500093", cpu_stall, cpu_inst);
        end
    endtask

    task automatic test_loop;
        logic [31:0] seq [3];
        int cyc, bad, late, timeouts, base;
        seq = '{32'h0, 32'h4, 32'h8};
        bad = 0; late = 0; timeouts = 0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        base = req_count;
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                cpu_pc = seq[k];
                wait_ready(20, cyc);
                if (cpu_stall) timeouts++;
                if (cpu_inst !== mem_word(seq[k])) bad++;
                if (it > 0) late += cyc;
            end
        end
        tests++;
        if (timeouts != 0) begin fails++; $display("FAIL loop_timeout: got %0d want 0", timeouts); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL loop_data: %0d wrong words want 0", bad); end
        tests++;
        if (late != 0) begin fails++; $display("FAIL loop_hit_latency: %0d stall cycles want 0", late); end
        tests++;
        if (req_count - base != 3) begin fails++; $display("FAIL loop_requests: got %0d want 3", req_count - base); end
    endtask

    task automatic test_alias;
        int cyc;
        @(negedge clk);
        cpu_pc = 32'h20;
        #1;
        tests++;
        if (cpu_stall !== 1'b1) begin fails++; $display("FAIL alias32_miss: got %b want 1", cpu_stall); end
        wait_ready(20, cyc);
        tests++;
        if (cpu_stall !== 1'b0 || cpu_inst !== mem_word(32'h20) || mem_addr !== 32'h20) begin
            fails++;
            $display("FAIL alias32_fill: stall=%b inst=%h addr=%h", cpu_stall, cpu_inst, mem_addr);
        end
        @(negedge clk);
        cpu_pc = 32'h0;
        #1;
        tests++;
        if (cpu_stall !== 1'b1) begin fails++; $display("FAIL alias0_evicted: got %b want 1", cpu_stall); end
        @(posedge clk);
        #1;
        tests++;
        if (mem_addr !== 32'h0) begin fails++; $display("FAIL alias0_addr: got %h want 0", mem_addr); end
        wait_ready(20, cyc);
        tests++;
        if (cpu_stall !== 1'b0 || cpu_inst !== 32'h00500093) begin
            fails++;
            $display("FAIL alias0_fill: stall=%b inst=%h want stall=0 inst=00500093", cpu_stall, cpu_inst);
        end
    endtask

    task automatic test_flush_refill;
        int cyc, base;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush  = 1'b0;
        cpu_pc = 32'h8;
        wait_ready(20, cyc);
        tests++;
        if (cpu_stall !== 1'b0 || mem_addr !== 32'h8) begin
            fails++;
            $display("FAIL pc8_fill: stall=%b addr=%h want stall=0 addr=8", cpu_stall, mem_addr);
        end
        base = req_count;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (cpu_stall !== 1'b1) begin fails++; $display("FAIL flush_clears: got %b want 1", cpu_stall); end
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (cpu_stall !== 1'b1) begin fails++; $display("FAIL flush_fill_cycle: got %b want 1", cpu_stall); end
        @(posedge clk);
        #1;
        tests++;
        if (cpu_stall !== 1'b0 || cpu_inst !== mem_word(32'h8)) begin
            fails++;
            $display("FAIL flush_refill: stall=%b inst=%h want stall=0 inst=%h", cpu_stall, cpu_inst, mem_word(32'h8));
        end
        tests++;
        if (mem_addr !== 32'h8 || req_count != base) begin
            fails++;
            $display("FAIL flush_no_request: addr=%h new_reqs=%0d want addr=8 new_reqs=0", mem_addr, req_count - base);
        end
    endtask

    task automatic test_ignore_and_reset;
        man_stall = 1'b1;
        man_inst  = '0;
        ctl_auto  = 1'b0;
        @(negedge clk);
        cpu_pc = 32'h40;
        @(posedge clk);
        #1;
        tests++;
        if (mem_addr !== 32'h40) begin fails++; $display("FAIL issue_addr: got %h want 40", mem_addr); end
        @(negedge clk);
        man_stall = 1'b0;
        man_inst  = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        man_stall = 1'b1;
        man_inst  = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            tests++;
            if (cpu_stall !== 1'b1 || cpu_inst !== mem_word(32'h8)) begin
                fails++;
                $display("FAIL early_pulse_ignored: stall=%b inst=%h want stall=1 inst=%h", cpu_stall, cpu_inst, mem_word(32'h8));
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset  = 1'b0;
        cpu_pc = 32'h8;
        #1;
        tests++;
        if (cpu_stall !== 1'b1 || mem_addr !== 32'h0 || cpu_inst !== 32'h0) begin
            fails++;
            $display("FAIL reset_in_wait: stall=%b addr=%h inst=%h want 1/0/0", cpu_stall, mem_addr, cpu_inst);
        end
        @(posedge clk);
        #1;
        tests++;
        if (mem_addr !== 32'h8) begin fails++; $display("FAIL reset_valid_cleared: addr=%h want 8", mem_addr); end
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_loop();
        test_alias();
        test_flush_refill();
        test_ignore_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
